// File: rtl/ascon_inv_permutation.sv
// ascon_inv_permutation: iterative inverse ASCON permutation, one inverse round per clock.
// Defining ASCON_INV_PROBE_EN adds the probe_lin0..4 and probe_round observation ports.
module ascon_inv_permutation (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  rounds_in,
    input  logic [63:0] x0_in,
    input  logic [63:0] x1_in,
    input  logic [63:0] x2_in,
    input  logic [63:0] x3_in,
    input  logic [63:0] x4_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] x0_out,
    output logic [63:0] x1_out,
    output logic [63:0] x2_out,
    output logic [63:0] x3_out,
    output logic [63:0] x4_out
`ifdef ASCON_INV_PROBE_EN
    ,
    output logic [63:0] probe_lin0,
    output logic [63:0] probe_lin1,
    output logic [63:0] probe_lin2,
    output logic [63:0] probe_lin3,
    output logic [63:0] probe_lin4,
    output logic [3:0]  probe_round
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int k);
        return (v << k) | (v >> (64 - k));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int k);
        return (v >> k) | (v << (64 - k));
    endfunction

    // Sigma is a circulant 1 + t^a + t^b with Sigma^64 = I, so its inverse is
    // Sigma^63 = prod Sigma^(2^j); bit k of the result selects ROR(x,k).
    function automatic logic [63:0] inv_mask(input int a, input int b);
        logic [63:0] acc, f, nx;
        acc = 64'd1;
        for (int j = 0; j < 6; j++) begin
            f = 64'd1 ^ (64'd1 << ((a << j) % 64)) ^ (64'd1 << ((b << j) % 64));
            nx = '0;
            for (int k = 0; k < 64; k++)
                if (f[k]) nx = nx ^ rotl(acc, k);
            acc = nx;
        end
        return acc;
    endfunction

    function automatic logic [63:0] sig_inv(input logic [63:0] v, input logic [63:0] m);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++)
            if (m[k]) y = y ^ ror(v, k);
        return y;
    endfunction

    localparam logic [63:0] M [5] = '{inv_mask(19, 28), inv_mask(61, 39), inv_mask(1, 6),
                                      inv_mask(10, 17), inv_mask(7, 41)};
    localparam logic [4:0] SBI [32] = '{
        5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
        5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
        5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
        5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2};

    state_t      st, st_n;
    logic [3:0]  cnt, r, n;
    logic [63:0] x   [5];
    logic [63:0] lin [5];
    logic [63:0] nx  [5];
    logic [4:0]  v;

    assign n = (rounds_in == 4'd0 || rounds_in > 4'd12) ? 4'd12 : rounds_in;

    always_comb begin
        v = '0;
        for (int i = 0; i < 5; i++) lin[i] = sig_inv(x[i], M[i]);
        for (int j = 0; j < 64; j++) begin
            v = SBI[{lin[0][j], lin[1][j], lin[2][j], lin[3][j], lin[4][j]}];
            nx[0][j] = v[4];
            nx[1][j] = v[3];
            nx[2][j] = v[2];
            nx[3][j] = v[1];
            nx[4][j] = v[0];
        end
        nx[2] = nx[2] ^ {56'd0, 4'hf - r, r};
    end

    always_comb begin
        st_n = (st == IDLE && in_valid)   ? RUN  :
               (st == RUN && cnt == 4'd1) ? DONE :
               (st == DONE && out_ready)  ? IDLE : st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
            r   <= '0;
            x   <= '{default: '0};
        end else begin
            st <= st_n;
            if (st == IDLE && in_valid) begin
                cnt <= n;
                r   <= 4'd11;
                x   <= '{x0_in, x1_in, x2_in, x3_in, x4_in};
            end else if (st == RUN) begin
                cnt <= cnt - 4'd1;
                r   <= r - 4'd1;
                x   <= nx;
            end
        end
    end

    assign in_ready  = st == IDLE;
    assign out_valid = st == DONE;
    assign x0_out    = x[0];
    assign x1_out    = x[1];
    assign x2_out    = x[2];
    assign x3_out    = x[3];
    assign x4_out    = x[4];

`ifdef ASCON_INV_PROBE_EN
    assign probe_lin0  = st == RUN ? lin[0] : '0;
    assign probe_lin1  = st == RUN ? lin[1] : '0;
    assign probe_lin2  = st == RUN ? lin[2] : '0;
    assign probe_lin3  = st == RUN ? lin[3] : '0;
    assign probe_lin4  = st == RUN ? lin[4] : '0;
    assign probe_round = st == RUN ? r : '0;
`endif
endmodule

// File: tb/tb_ascon_inv_permutation.sv
// tb_ascon_inv_permutation: round-trip checks of the inverse core against a forward ASCON model.
module tb_ascon_inv_permutation;
    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [3:0]   rounds_in = 0;
    logic [319:0] si = '0;
    logic [63:0]  x0_out, x1_out, x2_out, x3_out, x4_out;
    logic         in_ready, out_valid;
    logic [319:0] so;

    ascon_inv_permutation dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rounds_in(rounds_in),
        .x0_in(si[63:0]), .x1_in(si[127:64]), .x2_in(si[191:128]), .x3_in(si[255:192]),
        .x4_in(si[319:256]), .out_valid(out_valid), .out_ready(out_ready),
        .x0_out(x0_out), .x1_out(x1_out), .x2_out(x2_out), .x3_out(x3_out), .x4_out(x4_out));

    assign so = {x4_out, x3_out, x2_out, x1_out, x0_out};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   rin;
        logic [319:0] si;
        logic [319:0] se;
    } vec_t;

    int tests = 0, fails = 0;
    int inv_t [32] = '{20, 26, 7, 13, 0, 9, 14, 18, 10, 6, 29, 1, 25, 21, 19, 30,
                       24, 22, 11, 17, 3, 5, 28, 31, 23, 27, 4, 8, 15, 12, 16, 2};
    int fwd [32];
    vec_t tbl [9];

    function automatic logic [63:0] ror(logic [63:0] v, int k);
        return (v >> k) | (v << (64 - k));
    endfunction

    function automatic int nrm(logic [3:0] rin);
        return (rin == 0 || rin > 12) ? 12 : int'(rin);
    endfunction

    // Forward p^n: constant addition, S-box (inverse of the given table), linear layer.
    function automatic logic [319:0] perm(logic [319:0] s, int n);
        logic [63:0] x [5];
        logic [63:0] t [5];
        logic [4:0]  w;
        logic [319:0] o;
        for (int i = 0; i < 5; i++) x[i] = s[i*64 +: 64];
        for (int rr = 12 - n; rr < 12; rr++) begin
            x[2] = x[2] ^ 64'(((15 - rr) << 4) | rr);
            for (int j = 0; j < 64; j++) begin
                w = 5'(fwd[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}]);
                for (int i = 0; i < 5; i++) t[i][j] = w[4-i];
            end
            x[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
            x[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
            x[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
            x[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
            x[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        end
        for (int i = 0; i < 5; i++) o[i*64 +: 64] = x[i];
        return o;
    endfunction

    function automatic logic [319:0] rnd();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [329:0] got, input logic [329:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic start_job(input logic [3:0] rin, input logic [319:0] s);
        int b = 0;
        rounds_in = rin;
        si = s;
        in_valid = 1;
        while (!in_ready && b < 50) begin
            @(posedge clk); #1; b++;
        end
        if (b >= 50) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stayed %b", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic job(input string nm, input logic [3:0] rin, input logic [319:0] s,
                       input logic [319:0] e);
        int lat;
        start_job(rin, s);
        wait_done(lat);
        chk({nm, "_state"}, 330'(so), 330'(e));
        chk({nm, "_lat"}, 330'(lat), 330'(nrm(rin)));
        consume();
    endtask

    initial begin
        logic [319:0] o;
        int lat, opts [3], seen;
        opts = '{6, 8, 12};
        for (int i = 0; i < 32; i++) fwd[inv_t[i]] = i;

        in_valid = 1;
        si = rnd();
        rounds_in = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {in_ready, out_valid, so}, {1'b1, 1'b0, 320'd0});
        in_valid = 0;
        rst = 0;

        tbl[0] = '{4'd1, 320'd0, {64'd0, 64'd0, 64'hFFFFFFFFFFFFFFB4, 64'd0, 64'hFFFFFFFFFFFFFFFF}};
        for (int i = 1; i < 9; i++) begin
            o = rnd();
            tbl[i].rin = (i == 1) ? 4'd1 : (i == 2) ? 4'd2 : (i == 3) ? 4'd3 : (i == 4) ? 4'd11 :
                         (i == 5) ? 4'd12 : (i == 6) ? 4'd0 : (i == 7) ? 4'd15 : 4'd13;
            tbl[i].si = perm(o, nrm(tbl[i].rin));
            tbl[i].se = o;
        end
        for (int i = 0; i < 9; i++) job($sformatf("vec%0d", i), tbl[i].rin, tbl[i].si, tbl[i].se);

        o = rnd();
        job("r12", 4'd12, perm(o, 12), o);
        job("r0", 4'd0, perm(o, 12), o);
        job("r15", 4'd15, perm(o, 12), o);

        o = rnd();
        start_job(4'd12, perm(o, 12));
        wait_done(lat);
        chk("bp_lat", 330'(lat), 330'(12));
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("bp_hold%0d", c), {out_valid, in_ready, so}, {1'b1, 1'b0, o});
            @(posedge clk); #1;
        end
        out_ready = 1;
        chk("bp_ready_cycle", {in_ready, out_valid}, {1'b0, 1'b1});
        @(posedge clk); #1;
        out_ready = 0;
        chk("bp_release", {in_ready, out_valid}, {1'b1, 1'b0});

        start_job(4'd12, perm(rnd(), 12));
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrun_reset", {in_ready, out_valid, so}, {1'b1, 1'b0, 320'd0});
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("midrun_no_pulse", 330'(seen), 330'(0));
        o = rnd();
        job("after_reset", 4'd8, perm(o, 8), o);

        o = rnd();
        start_job(4'd6, perm(o, 6));
        in_valid = 1;
        si = rnd();
        rounds_in = 4'd2;
        wait_done(lat);
        in_valid = 0;
        chk("hold_state", 330'(so), 330'(o));
        chk("hold_lat", 330'(lat), 330'(6));
        consume();
        chk("hold_idle", {in_ready, out_valid}, {1'b1, 1'b0});

        for (int i = 0; i < 1000; i++) begin
            logic [3:0] rin;
            rin = 4'(opts[$urandom_range(0, 2)]);
            o = rnd();
            job($sformatf("rt%0d", i), rin, perm(o, nrm(rin)), o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ascon_inv_permutation.md
# ascon_inv_permutation

Iterative inverse ASCON permutation core. It undoes p^a (a = 1..12 rounds) on a 320-bit state, one inverse round per clock. Each inverse round applies the inverse linear diffusion layer, then the inverse 5-bit S-box, then strips the round constant. It sits beside the forward round-function datapath and serves the decryption-side analysis flows and round-trip self-check of the permutation, using the same five 64-bit lane convention (x0..x4).

## Interface
Parameters:
- none

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Reset. Synchronous, active-high.
- in_valid  input  1  Source presents a state and round count.
- in_ready  output  1  Core can accept a state. High only in IDLE.
- rounds_in  input  4  Number of rounds a to invert. Values 1..12 are legal; 0 and 13..15 are treated as 12.
- x0_in .. x4_in  input  64 each  Permuted state, one bus per lane.
- out_valid  output  1  Result is available.
- out_ready  input  1  Sink accepts the result.
- x0_out .. x4_out  output  64 each  Recovered state, driven directly from the state register.
- Macro-gated (see Configuration): probe_lin0 .. probe_lin4 (output, 64 each) and probe_round (output, 4).

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, load x*_in into the state register, load cnt=N (normalised rounds_in) and r=11, then go to RUN.
  - RUN: each cycle performs one inverse round, then cnt--, r--. When cnt reaches 0 after the update, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Inverse round, applied to the register value X:
  1. Linear inverse: Li = Σi⁻¹(Xi) per lane. Σi⁻¹ is the unique GF(2)^64 inverse of Σi:
     - Σ0(x) = x^ROR(x,19)^ROR(x,28)
     - Σ1(x) = x^ROR(x,61)^ROR(x,39)
     - Σ2(x) = x^ROR(x,1)^ROR(x,6)
     - Σ3(x) = x^ROR(x,10)^ROR(x,17)
     - Σ4(x) = x^ROR(x,7)^ROR(x,41)
     - Any purely combinational realisation is acceptable, e.g. an XOR of a fixed rotation set.
  2. Inverse S-box, bit-sliced: for each bit j, the 5-bit value {L0[j],L1[j],L2[j],L3[j],L4[j]} (L0 is the MSB) maps through the table 20,26,7,13,0,9,14,18,10,6,29,1,25,21,19,30,24,22,11,17,3,5,28,31,23,27,4,8,15,12,16,2 (indexed 0..31).
  3. Constant removal: x2 ^= {56'b0, c_r}, where c_r = {4'hF - r, r[3:0]}.
- r runs 11 down to 12-N, so the first inverse round uses constant 0x4b and the last uses c_(12-N). For N=12 the last constant is 0xf0.
- in_valid is ignored outside IDLE. rounds_in and x*_in are sampled only at acceptance.

## Timing
- Reset values: state register 0, cnt 0, r 0, FSM in IDLE, in_ready 1, out_valid 0, all x*_out 0, all probes 0.
- Latency: if acceptance happens at edge t, out_valid rises after edge t+N. This is N cycles in RUN.
- Throughput: one job per N+2 cycles at best.
- Output hold: x*_out and out_valid stay stable while out_valid && !out_ready.
- Return to IDLE: DONE with out_ready moves to IDLE on that edge, and in_ready reasserts in the next cycle. A new job is never accepted in the same cycle the result is consumed.
- Reset mid-RUN or in DONE: the core returns to reset values on that edge. The partial result is discarded and out_valid never pulses.
- Simultaneous rst and in_valid: reset wins and nothing is accepted.
- x*_out is visible combinationally from the register during RUN, but is only defined as a result when out_valid=1.

## Configuration
- ASCON_INV_PROBE_EN
  - Defined: adds ports probe_lin0..probe_lin4, the current Σ⁻¹ output (inverse S-box input), and probe_round, the current r. Probes are valid only during RUN and are 0 otherwise. They exist for fault-injection and power-analysis hooks.
  - Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- All-zero state, rounds_in=1: out_valid after 1 RUN cycle with x0=FFFFFFFFFFFFFFFF, x1=0, x2=FFFFFFFFFFFFFFB4, x3=0, x4=0.
- Round trip: 1000 random states × rounds_in ∈ {6,8,12}, pre-permuted by the golden forward model. The output equals the original state exactly, and out_valid rises exactly N cycles after acceptance.
- rounds_in=0 and rounds_in=15: result and latency identical to rounds_in=12 for the same input.
- Back-pressure: out_ready held low for 20 cycles in DONE. Outputs stay constant and in_ready stays 0; in_ready=1 on the cycle after out_ready is asserted.
- Reset asserted on the 5th RUN cycle of a 12-round job: next cycle out_valid=0, in_ready=1, x*_out=0. A following job completes correctly.
- in_valid held high during RUN with different data: that data is ignored and the result corresponds only to the accepted job.
